m_msg_buffer: RTL and testbench

M_MSG_BUFFER -- requirements
Module: m_msg_buffer

---
 rtl/m_msg_defs.sv | 22 ++
 rtl/m_msg_ram.sv | 41 ++++
 rtl/m_msg_buffer.sv | 155 +++++++++++++++
 tb/tb_m_msg_buffer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/m_msg_defs.sv
// Shared definitions for the message buffer: FSM state encoding, printable
// character bounds, buffer geometry and the newline code.
package m_msg_defs;

    typedef enum logic [1:0] {
        StClear = 2'd0,
        StRecv  = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam logic [7:0]  PrintLo     = 8'h20;
    localparam logic [7:0]  PrintHi     = 8'h7E;
    localparam int unsigned BufDepth    = 64;
    localparam int unsigned AddrW       = 6;
    localparam logic [5:0]  LastAddr    = 6'(BufDepth - 1);
    localparam logic [7:0]  NewlineChar = 8'h0A;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= PrintLo) && (c <= PrintHi);
    endfunction

endpackage

// File: rtl/m_msg_ram.sv
// 64x8 character store with one synchronous write port and one registered
// read port. A read and write to the same entry in one cycle returns the
// old contents.
// Ports:
//   clk, rst        clock, synchronous active-high reset (read register only)
//   we/waddr/wdata  write port
//   raddr/rdata     read address, registered read data (FILL_CHAR on reset)
module m_msg_ram
    import m_msg_defs::*;
#(
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [7:0]       rdata
);

    logic [7:0] mem_q [BufDepth];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= FILL_CHAR;
        end else begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/m_msg_buffer.sv
// Display message buffer: receives SPI bytes into a 4x16 character store,
// sanitising non-printable bytes, and serves a registered read port to the
// display scanner. A clear sweep fills every entry with FILL_CHAR.
// Optional feature: define M_MSG_BUFFER_NEWLINE_EN to make 8'h0A jump to the
// start of the next row instead of being stored.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clr                 wipe buffer and restart the message
//   wr_valid/wr_data    incoming byte, accepted when wr_valid && wr_ready
//   wr_ready            high only while receiving and clr is low
//   rd_addr/rd_data     {row, col} address, data one cycle later
//   wr_index            next write position
//   busy/full/msg_done  clearing / buffer full / one-cycle end-of-message
module m_msg_buffer
    import m_msg_defs::*;
#(
    parameter logic [7:0]  FILL_CHAR = 8'h20,
    parameter logic [7:0]  TERM_CHAR = 8'h00,
    parameter int unsigned LINE_LEN  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [5:0] wr_index,
    output logic       busy,
    output logic       full,
    output logic       msg_done
);

    // Row arithmetic below uses wr_index[5:4], so the geometry is fixed.
    if (LINE_LEN * 4 != BufDepth) begin : g_bad_line_len
        $error("LINE_LEN must be 16");
    end

    state_e     state_q, state_d;
    logic [5:0] sweep_q, sweep_d;
    logic [5:0] idx_q, idx_d;
    logic       full_q, full_d;
    logic       done_q, done_d;

    logic       accept;
    logic       we;
    logic [5:0] waddr;
    logic [7:0] wdata;

    assign wr_ready = (state_q == StRecv) && !clr;
    // rst outranks a simultaneous handshake.
    assign accept   = wr_valid && wr_ready && !rst;

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        idx_d   = idx_q;
        full_d  = full_q;
        done_d  = 1'b0;
        we      = 1'b0;
        waddr   = idx_q;
        wdata   = FILL_CHAR;

        if (clr) begin
            // No write in the clr cycle; the sweep restarts at entry 0.
            state_d = StClear;
            sweep_d = '0;
            idx_d   = '0;
            full_d  = 1'b0;
        end else begin
            unique case (state_q)
                StClear: begin
                    we      = 1'b1;
                    waddr   = sweep_q;
                    sweep_d = sweep_q + 6'd1;
                    if (sweep_q == LastAddr) begin
                        state_d = StRecv;
                        idx_d   = '0;
                    end
                end
                StRecv: begin
                    if (accept) begin
                        if (wr_data == TERM_CHAR) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end
`ifdef M_MSG_BUFFER_NEWLINE_EN
                        else if (wr_data == NewlineChar) begin
                            if (idx_q[5:4] == 2'd3) begin
                                full_d  = 1'b1;
                                done_d  = 1'b1;
                                state_d = StDone;
                            end else begin
                                idx_d = {idx_q[5:4] + 2'd1, 4'b0000};
                            end
                        end
`endif
                        else begin
                            we    = 1'b1;
                            wdata = is_printable(wr_data) ? wr_data : FILL_CHAR;
                            if (idx_q == LastAddr) begin
                                full_d  = 1'b1;
                                done_d  = 1'b1;
                                state_d = StDone;
                            end else begin
                                idx_d = idx_q + 6'd1;
                            end
                        end
                    end
                end
                StDone: begin
                end
                default: begin
                    state_d = StClear;
                    sweep_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StClear;
            sweep_q <= '0;
            idx_q   <= '0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            idx_q   <= idx_d;
            full_q  <= full_d;
            done_q  <= done_d;
        end
    end

    m_msg_ram #(
        .FILL_CHAR (FILL_CHAR)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we && !rst),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign busy     = (state_q == StClear);
    assign full     = full_q;
    assign wr_index = idx_q;
    assign msg_done = done_q;

endmodule

// File: tb/tb_m_msg_buffer.sv
module tb_m_msg_buffer;

    localparam logic [7:0] Fill = 8'h20;
    localparam logic [7:0] Term = 8'h00;

    logic       clk = 1'b0;
    logic       rst, clr, wr_valid;
    logic [7:0] wr_data;
    logic [5:0] rd_addr;
    logic       wr_ready, busy, full, msg_done;
    logic [7:0] rd_data;
    logic [5:0] wr_index;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    m_msg_buffer u_dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_index (wr_index),
        .busy     (busy),
        .full     (full),
        .msg_done (msg_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: clear countdown, message index and a byte array.
    bit        m_live = 0;
    int        m_clear_left, m_idx;
    bit        m_full, m_done, m_pulse, m_rd_known;
    logic [7:0] m_rd;
    logic [7:0] m_mem [64];
    bit        m_known [64];

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1; m_clear_left = 64; m_idx = 0; m_full = 0; m_done = 0;
            m_pulse = 0; m_rd = Fill; m_rd_known = 1;
        end else if (m_live) begin
            m_rd = m_mem[rd_addr];
            m_rd_known = m_known[rd_addr];
            m_pulse = 0;
            if (clr) begin
                m_clear_left = 64; m_idx = 0; m_full = 0; m_done = 0;
            end else if (m_clear_left > 0) begin
                m_mem[64 - m_clear_left] = Fill;
                m_known[64 - m_clear_left] = 1;
                m_clear_left--;
            end else if (!m_done && wr_valid) begin
                if (wr_data == Term) begin
                    m_done = 1; m_pulse = 1;
                end
`ifdef M_MSG_BUFFER_NEWLINE_EN
                else if (wr_data == 8'h0A) begin
                    if (m_idx >= 48) begin
                        m_full = 1; m_done = 1; m_pulse = 1;
                    end else begin
                        m_idx = (m_idx / 16 + 1) * 16;
                    end
                end
`endif
                else begin
                    m_mem[m_idx] = (wr_data >= 8'h20 && wr_data <= 8'h7E) ? wr_data : Fill;
                    m_known[m_idx] = 1;
                    if (m_idx == 63) begin
                        m_full = 1; m_done = 1; m_pulse = 1;
                    end else begin
                        m_idx++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (msg_done === 1'b1) pulses++;
        if (m_live) begin
            chk("busy", busy, m_clear_left > 0);
            chk("wr_ready", wr_ready, (m_clear_left == 0) && !m_done && !clr);
            chk("wr_index", wr_index, m_idx);
            chk("full", full, m_full);
            chk("msg_done", msg_done, m_pulse);
            if (m_rd_known) chk("rd_data", rd_data, m_rd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sweep(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic do_clear();
        int n;
        clr = 1'b1;
        step();
        clr = 1'b0;
        wait_sweep(n);
        chk("sweep_len", n, 64);
    endtask

    task automatic send(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        chk("send_ready", wr_ready, 1'b1);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic read(input logic [5:0] a, input logic [7:0] exp, input string name);
        rd_addr = a;
        step();
        chk(name, rd_data, exp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p0;
        rst = 1'b1; clr = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; rd_addr = 6'd0;
        step();
        rst = 1'b0;
        chk("rst_busy", busy, 1'b1);
        chk("rst_ready", wr_ready, 1'b0);
        chk("rst_index", wr_index, 6'd0);
        chk("rst_full", full, 1'b0);
        chk("rst_done", msg_done, 1'b0);
        chk("rst_rd", rd_data, 8'h20);
        wait_sweep(n);
        chk("rst_sweep_len", n, 64);
        chk("ready_after_sweep", wr_ready, 1'b1);
        for (int i = 0; i < 64; i++) read(6'(i), 8'h20, "cleared_entry");

        // "HI" then terminator.
        p0 = pulses;
        send(8'h48);
        send(8'h49);
        send(8'h00);
        chk("hi_done", msg_done, 1'b1);
        chk("hi_ready", wr_ready, 1'b0);
        chk("hi_index", wr_index, 6'd2);
        step();
        chk("hi_done_width", msg_done, 1'b0);
        read(6'd0, 8'h48, "hi_entry0");
        read(6'd1, 8'h49, "hi_entry1");
        repeat (3) step();
        chk("hi_pulses", pulses - p0, 1);
        chk("done_hold_index", wr_index, 6'd2);

        // Non-printable substitution and read-before-write.
        do_clear();
        rd_addr = 6'd0;
        send(8'h41);
        chk("rbw_old", rd_data, 8'h20);
        step();
        chk("rbw_new", rd_data, 8'h41);
        send(8'h07);
        chk("bell_index", wr_index, 6'd2);
        read(6'd1, 8'h20, "bell_entry");
`ifdef M_MSG_BUFFER_NEWLINE_EN
        do_clear();
        send(8'h41);
        send(8'h0A);
        send(8'h42);
        chk("nl_index", wr_index, 6'd17);
        read(6'd0, 8'h41, "nl_entry0");
        read(6'd16, 8'h42, "nl_entry16");
`else
        send(8'h0A);
        chk("nl_index", wr_index, 6'd3);
        read(6'd2, 8'h20, "nl_entry");
`endif

        // clr wins over a simultaneous byte.
        do_clear();
        send(8'h5A);
        wr_valid = 1'b1; wr_data = 8'h5A; clr = 1'b1;
        step();
        wr_valid = 1'b0; clr = 1'b0;
        chk("clr_busy", busy, 1'b1);
        chk("clr_index", wr_index, 6'd0);
        wait_sweep(n);
        chk("clr_sweep_len", n, 64);
        read(6'd0, 8'h20, "clr_entry0");

        // Fill all 64 entries.
        p0 = pulses;
        for (int i = 0; i < 64; i++) send(8'h41);
        chk("full_flag", full, 1'b1);
        chk("full_index", wr_index, 6'd63);
        chk("full_done", msg_done, 1'b1);
        wr_valid = 1'b1; wr_data = 8'h42;
        for (int i = 0; i < 5; i++) begin
            chk("full_no_ready", wr_ready, 1'b0);
            step();
        end
        wr_valid = 1'b0;
        chk("full_hold_index", wr_index, 6'd63);
        chk("full_pulses", pulses - p0, 1);
        read(6'd63, 8'h41, "full_entry63");

        // Restart of sweep by clr and by rst mid-sweep.
        clr = 1'b1; step(); clr = 1'b0;
        repeat (20) step();
        do_clear();
        clr = 1'b1; step(); clr = 1'b0;
        repeat (10) step();
        rst = 1'b1; wr_valid = 1'b1; wr_data = 8'h41;
        step();
        rst = 1'b0; wr_valid = 1'b0;
        chk("midrst_index", wr_index, 6'd0);
        wait_sweep(n);
        chk("midrst_sweep_len", n, 64);

        // rst mid-message with a pending byte.
        send(8'h43);
        rst = 1'b1; clr = 1'b1; wr_valid = 1'b1; wr_data = 8'h44;
        step();
        rst = 1'b0; clr = 1'b0; wr_valid = 1'b0;
        chk("rst_prio_busy", busy, 1'b1);
        chk("rst_prio_index", wr_index, 6'd0);
        wait_sweep(n);
        chk("rst_prio_sweep", n, 64);
        read(6'd1, 8'h20, "rst_prio_entry1");
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
